control_unit: RTL and testbench

Hardwired control sequencer for the basic accumulator computer. It sits directly upstream of the datapath and drives every register write/increment/clear strobe, the common-bus source select, the ALU function select and the memory write strobe. It generates these from the instruction register contents, the datapath status flags and an internal timing counter (T0..T6). It implements the standard fetch / decode / indirect / execute cycle for memory-reference and register-reference instructions.

---
 rtl/control_unit.sv | 159 +++++++++++++++
 tb/tb_control_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired fetch/decode/indirect/execute sequencer for the basic accumulator computer.
// Optional HLT support is compiled in when CU_HALT_EN is defined.
module control_unit #(
    parameter int SC_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     IR,
    input  logic            ac_msb,
    input  logic            ac_zero,
    input  logic            dr_zero,
    input  logic            e_flag,
    output logic [2:0]      bus_sel,
    output logic [2:0]      alu_sel,
    output logic            AR_write,
    output logic            AR_increment,
    output logic            AR_clear,
    output logic            PC_write,
    output logic            PC_increment,
    output logic            PC_clear,
    output logic            DR_write,
    output logic            DR_increment,
    output logic            DR_clear,
    output logic            AC_write,
    output logic            AC_increment,
    output logic            AC_clear,
    output logic            IR_write,
    output logic            TR_write,
    output logic            OUTR_write,
    output logic            E_load,
    output logic            E_clear,
    output logic            E_complement,
    output logic            mem_write,
    output logic [SC_W-1:0] T,
    output logic            halted
);

`ifdef CU_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    typedef enum logic [SC_W-1:0] {
        T0 = SC_W'(0), T1 = SC_W'(1), T2 = SC_W'(2), T3 = SC_W'(3),
        T4 = SC_W'(4), T5 = SC_W'(5), T6 = SC_W'(6)
    } sc_e;

    localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
                           BUS_AC = 3'd4, BUS_IR = 3'd5, BUS_MEM = 3'd7;
    localparam logic [2:0] ALU_AND = 3'd0, ALU_ADD = 3'd1, ALU_LDA = 3'd2,
                           ALU_CMA = 3'd3, ALU_SHR = 3'd4, ALU_SHL = 3'd5;

    sc_e  sc_q, sc_d;
    logic i_q, i_d;
    logic halted_q, halted_d;
    logic [7:0] d;

    assign d = 8'b1 << IR[14:12];

    always_comb begin
        sc_d     = sc_q;
        i_d      = i_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (sc_q)
                T0: sc_d = T1;
                T1: sc_d = T2;
                T2: begin
                    sc_d = T3;
                    i_d  = IR[15];
                end
                T3: begin
                    if (d[7]) begin
                        sc_d = T0;
                        if (HALT_EN && !i_q && IR[0]) halted_d = 1'b1;
                    end else begin
                        sc_d = T4;
                    end
                end
                T4: sc_d = (d[3] || d[4]) ? T0 : T5;
                T5: sc_d = d[6] ? T6 : T0;
                default: sc_d = T0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_q     <= T0;
            i_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            sc_q     <= sc_d;
            i_q      <= i_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        bus_sel = BUS_NONE;  alu_sel = ALU_AND;
        AR_write = 1'b0;  AR_increment = 1'b0;  AR_clear = 1'b0;
        PC_write = 1'b0;  PC_increment = 1'b0;  PC_clear = 1'b0;
        DR_write = 1'b0;  DR_increment = 1'b0;  DR_clear = 1'b0;
        AC_write = 1'b0;  AC_increment = 1'b0;  AC_clear = 1'b0;
        IR_write = 1'b0;  TR_write = 1'b0;      OUTR_write = 1'b0;
        E_load = 1'b0;    E_clear = 1'b0;       E_complement = 1'b0;
        mem_write = 1'b0;
        if (!halted_q) begin
            case (sc_q)
                T0: begin bus_sel = BUS_PC; AR_write = 1'b1; end
                T1: begin bus_sel = BUS_MEM; IR_write = 1'b1; PC_increment = 1'b1; end
                T2: begin bus_sel = BUS_IR; AR_write = 1'b1; end
                T3: begin
                    if (!d[7]) begin
                        if (i_q) begin bus_sel = BUS_MEM; AR_write = 1'b1; end
                    end else if (!i_q) begin
                        // Register-reference: every set bit contributes its strobes.
                        AC_clear     = IR[11];
                        E_clear      = IR[10];
                        E_complement = IR[8];
                        AC_increment = IR[5];
                        if (IR[9]) begin AC_write = 1'b1; alu_sel = ALU_CMA; end
                        if (IR[7]) begin AC_write = 1'b1; E_load = 1'b1; alu_sel = ALU_SHR; end
                        if (IR[6]) begin AC_write = 1'b1; E_load = 1'b1; alu_sel = ALU_SHL; end
                        PC_increment = (IR[4] && !ac_msb) || (IR[3] && ac_msb) ||
                                       (IR[2] && ac_zero) || (IR[1] && !e_flag);
                    end
                end
                T4: begin
                    if (d[0] || d[1] || d[2] || d[6]) begin
                        bus_sel = BUS_MEM; DR_write = 1'b1;
                    end else if (d[3]) begin
                        bus_sel = BUS_AC; mem_write = 1'b1;
                    end else if (d[4]) begin
                        bus_sel = BUS_AR; PC_write = 1'b1;
                    end else if (d[5]) begin
                        bus_sel = BUS_PC; mem_write = 1'b1; AR_increment = 1'b1;
                    end
                end
                T5: begin
                    if (d[0]) begin AC_write = 1'b1; alu_sel = ALU_AND; end
                    else if (d[1]) begin AC_write = 1'b1; alu_sel = ALU_ADD; E_load = 1'b1; end
                    else if (d[2]) begin AC_write = 1'b1; alu_sel = ALU_LDA; end
                    else if (d[5]) begin bus_sel = BUS_AR; PC_write = 1'b1; end
                    else if (d[6]) DR_increment = 1'b1;
                end
                T6: begin
                    bus_sel = BUS_DR; mem_write = 1'b1; PC_increment = dr_zero;
                end
                default: ;
            endcase
        end
    end

    assign T      = sc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: each instruction is expanded into its expected
// per-cycle control words from the instruction-set description and compared cycle by cycle.
module tb_control_unit;

    typedef struct packed {
        logic       halted;
        logic [2:0] t;
        logic [2:0] bus;
        logic [2:0] alu;
        logic ar_w, ar_i, ar_c;
        logic pc_w, pc_i, pc_c;
        logic dr_w, dr_i, dr_c;
        logic ac_w, ac_i, ac_c;
        logic ir_w, tr_w, outr_w;
        logic e_ld, e_clr, e_cmp;
        logic mem_w;
    } ctl_t;

    localparam int W = $bits(ctl_t);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] IR = 16'h0;
    logic ac_msb = 1'b0, ac_zero = 1'b0, dr_zero = 1'b0, e_flag = 1'b0;
    logic [2:0] bus_sel, alu_sel, T;
    logic AR_write, AR_increment, AR_clear, PC_write, PC_increment, PC_clear;
    logic DR_write, DR_increment, DR_clear, AC_write, AC_increment, AC_clear;
    logic IR_write, TR_write, OUTR_write, E_load, E_clear, E_complement, mem_write, halted;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    control_unit #(.SC_W(3)) dut (
        .clk(clk), .reset(reset), .IR(IR),
        .ac_msb(ac_msb), .ac_zero(ac_zero), .dr_zero(dr_zero), .e_flag(e_flag),
        .bus_sel(bus_sel), .alu_sel(alu_sel),
        .AR_write(AR_write), .AR_increment(AR_increment), .AR_clear(AR_clear),
        .PC_write(PC_write), .PC_increment(PC_increment), .PC_clear(PC_clear),
        .DR_write(DR_write), .DR_increment(DR_increment), .DR_clear(DR_clear),
        .AC_write(AC_write), .AC_increment(AC_increment), .AC_clear(AC_clear),
        .IR_write(IR_write), .TR_write(TR_write), .OUTR_write(OUTR_write),
        .E_load(E_load), .E_clear(E_clear), .E_complement(E_complement),
        .mem_write(mem_write), .T(T), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [W-1:0] dut_word;
    assign dut_word = {halted, T, bus_sel, alu_sel,
                       AR_write, AR_increment, AR_clear, PC_write, PC_increment, PC_clear,
                       DR_write, DR_increment, DR_clear, AC_write, AC_increment, AC_clear,
                       IR_write, TR_write, OUTR_write, E_load, E_clear, E_complement, mem_write};

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t IR=%h)", tag, got, exp, $time, IR);
        end
    endtask

    function automatic ctl_t blank(input int t);
        ctl_t c;
        c = '0;
        c.t = 3'(t);
        return c;
    endfunction

    // Expand one instruction into the control words of each of its cycles.
    task automatic build_expected(input logic [15:0] ir);
        ctl_t c;
        logic [2:0] op;
        logic ind;
        op  = ir[14:12];
        ind = ir[15];
        c = blank(0); c.bus = 3'd2; c.ar_w = 1'b1; exp_q.push_back(c);
        c = blank(1); c.bus = 3'd7; c.ir_w = 1'b1; c.pc_i = 1'b1; exp_q.push_back(c);
        c = blank(2); c.bus = 3'd5; c.ar_w = 1'b1; exp_q.push_back(c);
        c = blank(3);
        if (op != 3'd7) begin
            if (ind) begin c.bus = 3'd7; c.ar_w = 1'b1; end
            exp_q.push_back(c);
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    c = blank(4); c.bus = 3'd7; c.dr_w = 1'b1; exp_q.push_back(c);
                    c = blank(5); c.ac_w = 1'b1; c.alu = op; c.e_ld = (op == 3'd1);
                    exp_q.push_back(c);
                end
                3'd3: begin c = blank(4); c.bus = 3'd4; c.mem_w = 1'b1; exp_q.push_back(c); end
                3'd4: begin c = blank(4); c.bus = 3'd1; c.pc_w = 1'b1; exp_q.push_back(c); end
                3'd5: begin
                    c = blank(4); c.bus = 3'd2; c.mem_w = 1'b1; c.ar_i = 1'b1; exp_q.push_back(c);
                    c = blank(5); c.bus = 3'd1; c.pc_w = 1'b1; exp_q.push_back(c);
                end
                default: begin
                    c = blank(4); c.bus = 3'd7; c.dr_w = 1'b1; exp_q.push_back(c);
                    c = blank(5); c.dr_i = 1'b1; exp_q.push_back(c);
                    c = blank(6); c.bus = 3'd3; c.mem_w = 1'b1; c.pc_i = dr_zero; exp_q.push_back(c);
                end
            endcase
        end else begin
            if (!ind) begin
                c.ac_c = ir[11];
                c.e_clr = ir[10];
                c.e_cmp = ir[8];
                c.ac_i = ir[5];
                if (ir[9]) begin c.ac_w = 1'b1; c.alu = 3'd3; end
                if (ir[7]) begin c.ac_w = 1'b1; c.e_ld = 1'b1; c.alu = 3'd4; end
                if (ir[6]) begin c.ac_w = 1'b1; c.e_ld = 1'b1; c.alu = 3'd5; end
                c.pc_i = (ir[4] & ~ac_msb) | (ir[3] & ac_msb) | (ir[2] & ac_zero) | (ir[1] & ~e_flag);
            end
            exp_q.push_back(c);
        end
    endtask

    // Consumes the expected queue one cycle at a time; abort_at>0 resets after that many cycles.
    task automatic apply_exp(input string tag, input int abort_at);
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            if (abort_at > 0 && n == abort_at) begin
                exp_q.delete();
                do_reset();
                return;
            end
            @(negedge clk);
            check(tag, dut_word, exp_q.pop_front());
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_reset();
        ctl_t c;
        c = blank(0); c.bus = 3'd2; c.ar_w = 1'b1;
        reset = 1'b1;
        #2;
        check("rst_async", dut_word, c);
        @(negedge clk);
        check("rst_hold", dut_word, c);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [15:0] ir, input logic [3:0] fl, input int abort_at);
        IR = ir;
        {ac_msb, ac_zero, dr_zero, e_flag} = fl;
        build_expected(ir);
        apply_exp(tag, abort_at);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[14:12] == 3'd7 && !w[15]) begin
            w[11:0] = w[11:0] & 12'hD3E;
            case ($urandom_range(0, 3))
                0: w[9] = 1'b1;
                1: w[7] = 1'b1;
                2: w[6] = 1'b1;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        #12;
        do_reset();
        run_instr("add_dir", 16'h1005, 4'b0000, 0);
        run_instr("and_ind", 16'h8005, 4'b1010, 0);
        run_instr("isz_dz1", 16'h6010, 4'b0010, 0);
        run_instr("isz_dz0", 16'h6010, 4'b1101, 0);
        run_instr("spa_pos", 16'h7010, 4'b0000, 0);
        run_instr("spa_neg", 16'h7010, 4'b1000, 0);
        run_instr("cla", 16'h7800, 4'b0000, 0);
        run_instr("sze_cir", 16'h7082, 4'b0000, 0);
        run_instr("io_nop", 16'hF400, 4'b0000, 0);
        run_instr("sta_ind", 16'hB123, 4'b0000, 0);
        run_instr("bsa_dir", 16'h5040, 4'b0000, 0);
        run_instr("add_abort", 16'h1005, 4'b0000, 4);
        run_instr("post_abort", 16'h2007, 4'b0000, 0);
        for (int k = 0; k < 400; k++)
            run_instr("random", rand_instr(), 4'($urandom), 0);
`ifdef CU_HALT_EN
        begin
            ctl_t h;
            IR = 16'h7001;
            build_expected(16'h7001);
            h = blank(0); h.halted = 1'b1;
            for (int k = 0; k < 10; k++) exp_q.push_back(h);
            apply_exp("halt", 0);
            do_reset();
        end
`else
        run_instr("hlt_nop", 16'h7001, 4'b0000, 0);
`endif
        run_instr("after_hlt", 16'h4321, 4'b0000, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
